// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the client request/response signals and the ALU-facing datapath of
// alu_arbiter.
//   slave  modport : the arbiter side (alu_arbiter uses this one)
//   master modport : the clients plus the combinational ALU
// Signals:
//   req[1:0]         level request, bit i = client i
//   a0/b0/op0        client 0 operands and ALU control code
//   a1/b1/op1        client 1 operands and ALU control code
//   alu_a/b/op       registered operands/control presented to the ALU
//   alu_r/alu_f      combinational ALU result and flags
//   gnt[1:0]         one-hot grant, high for the EXEC cycle
//   done, done_id    result-valid pulse and the client it belongs to
//   r, f             captured result/flags, held until the next capture
//   busy             arbiter not idle
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int N = 256
);
    logic [1:0]   req;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic [2:0]   op0;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic [2:0]   op1;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [N-1:0] alu_r;
    logic [3:0]   alu_f;
    logic [1:0]   gnt;
    logic         done;
    logic         done_id;
    logic [N-1:0] r;
    logic [3:0]   f;
    logic         busy;

    modport slave (
        input  req, a0, b0, op0, a1, b1, op1, alu_r, alu_f,
        output alu_a, alu_b, alu_op, gnt, done, done_id, r, f, busy
    );

    modport master (
        output req, a0, b0, op0, a1, b1, op1, alu_r, alu_f,
        input  alu_a, alu_b, alu_op, gnt, done, done_id, r, f, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter and sequencer in front of a shared combinational ALU.
// An operation takes three cycles: IDLE (arbitrate, latch the winner's
// operands), EXEC (ALU settles on the latched operands, gnt high), DONE
// (captured result/flags valid, done high).
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  alu_arbiter_if.slave -- client requests/operands, ALU operands and
//        result, grant/done/result outputs, busy
// -----------------------------------------------------------------------------
module alu_arbiter (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic last;      // client granted most recently; loses the next tie
    logic win;       // client that would be granted this cycle
    logic take;      // IDLE with at least one request: grant this edge
    logic id_q;      // client being served / last served

    // Winner selection: a lone requester wins; on a tie the client that was
    // not served last time wins.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        win = 1'b0;
        case (bus.req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
    end

    assign take = (state == IDLE) && (bus.req != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples pre-edge values regardless of block ordering.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = take ? EXEC : IDLE;
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register: gnt during EXEC, done during
    // DONE. Both come straight from flops, so they are clean one-cycle pulses
    // and drop immediately on reset.
    always_comb begin
        bus.gnt  = 2'b00;
        bus.done = 1'b0;
        bus.busy = (state != IDLE);
        case (state)
            EXEC:    bus.gnt  = id_q ? 2'b10 : 2'b01;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.done_id = id_q;

    // Datapath: operands are latched at grant and held until the next grant,
    // so the ALU inputs stay stable through EXEC and do not toggle while idle.
    // The result is captured at the end of EXEC.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the wide operand/result registers are reset too, because
        // reset must leave alu_*, r and f at zero; aborting an operation has
        // to clear a stale result rather than leave it visible.
        if (!rst) begin
            bus.alu_a  <= '0;
            bus.alu_b  <= '0;
            bus.alu_op <= '0;
            bus.r      <= '0;
            bus.f      <= '0;
            id_q       <= 1'b0;
            last       <= 1'b1;
        end else begin
            if (take) begin
                bus.alu_a  <= win ? bus.a1  : bus.a0;
                bus.alu_b  <= win ? bus.b1  : bus.b0;
                bus.alu_op <= win ? bus.op1 : bus.op0;
                id_q       <= win;
                last       <= win;
            end
            if (state == EXEC) begin
                bus.r <= bus.alu_r;
                bus.f <= bus.alu_f;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. The bench supplies the combinational
// ALU; expected results are pushed to a scoreboard queue when a request is
// driven and popped when the arbiter raises done.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N = 256;
    localparam logic [N-1:0] ONES = '1;
    localparam logic [N-1:0] MSB  = {1'b1, {(N-1){1'b0}}};

    logic clk;
    logic rst;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: flags f = {carry/borrow, zero, negative, parity}.
    function automatic logic [N+3:0] alu_model(input logic [N-1:0] a,
                                               input logic [N-1:0] b,
                                               input logic [2:0]   op);
        logic [N:0]   w;
        logic [N-1:0] res;
        logic         c;
        w   = '0;
        res = '0;
        c   = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; res = w[N-1:0]; c = w[N]; end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; res = w[N-1:0]; c = w[N]; end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = ~a;
            3'd6: begin res = a << 1; c = a[N-1]; end
            default: res = b;
        endcase
        return {c, (res == '0), res[N-1], ^res, res};
    endfunction

    assign {bus.alu_f, bus.alu_r} = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic         id;
        logic [N-1:0] r;
        logic [3:0]   f;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input logic id, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [2:0] op);
        exp_t e;
        logic [N+3:0] m;
        m    = alu_model(a, b, op);
        e.id = id;
        e.r  = m[N-1:0];
        e.f  = m[N+3:N];
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_done_id", bus.done_id, e.id);
                    check("sb_r", bus.r, e.r);
                    check("sb_f", bus.f, e.f);
                end
            end
        end
    end

    // Table of single operations
    typedef struct {
        logic [1:0]   req;
        logic [N-1:0] a0;
        logic [N-1:0] b0;
        logic [2:0]   op0;
        logic [N-1:0] a1;
        logic [N-1:0] b1;
        logic [2:0]   op1;
        logic [1:0]   exp_gnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic         wid;
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        logic [2:0]   eop;

        vecs[0] = '{2'b01, N'(1),  N'(1),    3'd2, N'(5),    N'(7),    3'd0, 2'b01};
        vecs[1] = '{2'b11, N'(10), N'(3),    3'd1, ONES,     N'(1),    3'd0, 2'b10};
        vecs[2] = '{2'b11, N'(3),  N'(10),   3'd1, N'(9),    N'(6),    3'd4, 2'b01};
        vecs[3] = '{2'b10, N'(4),  N'(4),    3'd0, MSB,      N'(0),    3'd6, 2'b10};
        vecs[4] = '{2'b10, N'(2),  N'(2),    3'd0, N'(240),  N'(15),   3'd3, 2'b10};
        vecs[5] = '{2'b11, N'(0),  N'(77),   3'd5, N'(1),    N'(1),    3'd0, 2'b01};
        vecs[6] = '{2'b01, N'(6),  N'(2748), 3'd7, N'(8),    N'(8),    3'd2, 2'b01};
        vecs[7] = '{2'b11, N'(1),  N'(1),    3'd0, N'(85),   N'(14),   3'd4, 2'b10};

        rst     = 1'b0;
        bus.req = 2'b00;
        bus.a0  = '0; bus.b0 = '0; bus.op0 = '0;
        bus.a1  = '0; bus.b1 = '0; bus.op1 = '0;

        // Reset values
        #3;
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_done_id", bus.done_id, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_r", bus.r, 0);
        check("rst_f", bus.f, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_op", bus.alu_op, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Table-driven single operations; operands are scrambled right after
        // the grant to show they were latched.
        for (int i = 0; i < 8; i++) begin
            bus.req = vecs[i].req;
            bus.a0 = vecs[i].a0; bus.b0 = vecs[i].b0; bus.op0 = vecs[i].op0;
            bus.a1 = vecs[i].a1; bus.b1 = vecs[i].b1; bus.op1 = vecs[i].op1;
            wid = vecs[i].exp_gnt[1];
            ea  = wid ? vecs[i].a1  : vecs[i].a0;
            eb  = wid ? vecs[i].b1  : vecs[i].b0;
            eop = wid ? vecs[i].op1 : vecs[i].op0;
            push_exp(wid, ea, eb, eop);

            @(posedge clk); #1;
            check($sformatf("v%0d_gnt", i), bus.gnt, vecs[i].exp_gnt);
            check($sformatf("v%0d_alu_a", i), bus.alu_a, ea);
            check($sformatf("v%0d_alu_b", i), bus.alu_b, eb);
            check($sformatf("v%0d_alu_op", i), bus.alu_op, eop);
            check($sformatf("v%0d_busy_exec", i), bus.busy, 1);
            check($sformatf("v%0d_done_exec", i), bus.done, 0);
            bus.req = 2'b00;
            bus.a0 = {8{$urandom}}; bus.a1 = {8{$urandom}};
            bus.b0 = {8{$urandom}}; bus.b1 = {8{$urandom}};

            @(posedge clk); #1;
            check($sformatf("v%0d_done", i), bus.done, 1);
            check($sformatf("v%0d_gnt_done", i), bus.gnt, 0);
            check($sformatf("v%0d_alu_a_held", i), bus.alu_a, ea);

            @(posedge clk); #1;
            check($sformatf("v%0d_done_low", i), bus.done, 0);
            check($sformatf("v%0d_busy_idle", i), bus.busy, 0);
            check($sformatf("v%0d_alu_b_held", i), bus.alu_b, eb);
        end

        // Reset during EXEC: no done, r/f cleared immediately.
        bus.req = 2'b10;
        bus.a1 = N'(33); bus.b1 = N'(44); bus.op1 = 3'd0;
        @(posedge clk); #1;
        check("rexec_gnt", bus.gnt, 2'b10);
        rst = 1'b0;
        #1;
        check("rexec_gnt0", bus.gnt, 0);
        check("rexec_done0", bus.done, 0);
        check("rexec_busy0", bus.busy, 0);
        check("rexec_r0", bus.r, 0);
        check("rexec_f0", bus.f, 0);
        check("rexec_alu_a0", bus.alu_a, 0);
        bus.req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rexec_busy_after", bus.busy, 0);
        check("rexec_r_after", bus.r, 0);

        // Tie from reset: grants 01,10,01,10 at 3-cycle spacing.
        bus.req = 2'b11;
        bus.a0 = N'(100); bus.b0 = N'(25); bus.op0 = 3'd1;
        bus.a1 = ONES;    bus.b1 = N'(2);  bus.op1 = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (k[0]) push_exp(1'b1, ONES, N'(2), 3'd0);
            else      push_exp(1'b0, N'(100), N'(25), 3'd1);
        end
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 1 : 3) @(posedge clk);
            #1;
            check($sformatf("tie%0d_gnt", k), bus.gnt, k[0] ? 2'b10 : 2'b01);
            check($sformatf("tie%0d_done_id", k), bus.done_id, k[0]);
            if (k == 3) bus.req = 2'b00;
        end
        repeat (2) @(posedge clk);
        #1;
        check("tie_busy_end", bus.busy, 0);

        // Request pulsed during DONE and withdrawn in IDLE: not served.
        bus.req = 2'b01;
        bus.a0 = N'(7); bus.b0 = N'(7); bus.op0 = 3'd4;
        push_exp(1'b0, N'(7), N'(7), 3'd4);
        @(posedge clk); #1;
        check("wd_gnt", bus.gnt, 2'b01);
        bus.req = 2'b00;
        @(posedge clk); #1;
        check("wd_done", bus.done, 1);
        bus.req = 2'b10;
        @(posedge clk); #1;
        bus.req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wd_busy%0d", k), bus.busy, 0);
            check($sformatf("wd_gnt%0d", k), bus.gnt, 0);
            @(posedge clk); #1;
        end

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
